// File: rtl/pulse_cdc_scheduler.sv
// Round-robin scheduler that shares one fast-to-slow pulse crossing among NREQ requesters,
// with per-requester pending counters and credit flow control matched to the crossing FIFO.
//
// state | meaning
// IDLE  | not issuing; pending counts retained
// RUN   | issuing one pulse per cycle while credits and pending pulses exist
// FLUSH | pending counts discarded; waits for all outstanding credits to return
module pulse_cdc_scheduler #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 4,
    parameter int CREDITS = 7,
    parameter int ID_W    = 2
) (
    input  logic            fast_clk,
    input  logic            rstn,
    input  logic            enable,
    input  logic            flush,
    input  logic [NREQ-1:0] req,
    input  logic            credit_ret,
    output logic            out_pulse,
    output logic [ID_W-1:0] out_id,
    output logic [3:0]      credits,
    output logic            busy,
    output logic [NREQ-1:0] ovf,
    output logic            cred_err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [3:0]       CRED_MAX = 4'(CREDITS);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt [NREQ];
    logic [ID_W-1:0]   rr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic              any_pending;
    logic              issue;
    logic              clear_cnt;
    logic [NREQ-1:0]   grant_vec;

    // Search begins one past the last served requester and wraps modulo NREQ.
    always_comb begin
        int idx;
        logic [ID_W-1:0] sel;
        grant_id    = '0;
        grant_found = 1'b0;
        any_pending = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            sel = ID_W'(idx);
            if (cnt[sel] != '0) begin
                any_pending = 1'b1;
                if (!grant_found) begin
                    grant_found = 1'b1;
                    grant_id    = sel;
                end
            end
        end
    end

    assign issue = (state == RUN) && (credits != 4'd0) && grant_found;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            grant_vec[i] = issue && (grant_id == ID_W'(i));
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush)       state_next = FLUSH;
                else if (enable) state_next = RUN;
            end
            RUN: begin
                if (flush)        state_next = FLUSH;
                else if (!enable) state_next = IDLE;
            end
            FLUSH: begin
                if (credits == CRED_MAX) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters are held at zero while entering or sitting in FLUSH, so req is ignored there.
    assign clear_cnt = (state_next == FLUSH) || (state == FLUSH);

    always_ff @(posedge fast_clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
            ovf   <= '0;
        end else begin
            state <= state_next;
            for (int i = 0; i < NREQ; i++) begin
                if (clear_cnt) begin
                    cnt[i] <= '0;
                end else begin
                    case ({req[i], grant_vec[i]})
                        2'b10: begin
                            if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                            else                   ovf[i] <= 1'b1;
                        end
                        2'b01:   cnt[i] <= cnt[i] - 1'b1;
                        default: cnt[i] <= cnt[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge fast_clk or negedge rstn) begin
        if (!rstn) begin
            credits   <= CRED_MAX;
            cred_err  <= 1'b0;
            out_pulse <= 1'b0;
            out_id    <= '0;
            rr        <= ID_W'(NREQ - 1);
        end else begin
            case ({issue, credit_ret})
                2'b10: credits <= credits - 4'd1;
                2'b01: begin
                    if (credits == CRED_MAX) cred_err <= 1'b1;
                    else                     credits  <= credits + 4'd1;
                end
                default: credits <= credits;
            endcase
            out_pulse <= issue;
            if (issue) begin
                out_id <= grant_id;
                rr     <= grant_id;
            end
        end
    end

    assign busy = (state != IDLE) || any_pending;

endmodule

// File: doc/pulse_cdc_scheduler.md
Name: pulse_cdc_scheduler

Overview:
- Shares one fast-to-slow pulse-crossing channel among NREQ fast-domain requesters.
- Counts pending pulses per requester and grants them round-robin.
- Issues at most one pulse per fast_clk cycle into the crossing FIFO.
- Uses credit-based flow control sized to the FIFO's usable depth, so no pulse is ever dropped inside the crossing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 4, width of each per-requester pending counter; saturates at 2^CNT_W-1.
- CREDITS, 7, outstanding-pulse limit; equals crossing FIFO depth minus 1.
- ID_W, 2, width of out_id; must satisfy 2^ID_W >= NREQ.

Ports:
- fast_clk, in, 1: clock; every port is in this domain.
- rstn, in, 1: reset, asynchronous, active-low.
- enable, in, 1: allows issuing when high.
- flush, in, 1: single-cycle command to discard all pending pulses and drain.
- req, in, NREQ: single-cycle pulse per requester; one pending pulse per asserted bit.
- credit_ret, in, 1: single-cycle pulse, already synchronised to fast_clk; one per pulse consumed on the slow side.
- out_pulse, out, 1: single-cycle pulse into the crossing channel.
- out_id, out, ID_W: index of the requester served by out_pulse; valid only when out_pulse=1.
- credits, out, 4: current available credits.
- busy, out, 1: high when state is not IDLE or any counter is non-zero.
- ovf, out, NREQ: sticky per-requester flag; set when a req is dropped at saturation.
- cred_err, out, 1: sticky; set when credit_ret arrives with credits==CREDITS.

Behaviour:
- Reset values: out_pulse=0, out_id=0, credits=CREDITS, ovf=0, cred_err=0, all counters=0, rr pointer=NREQ-1, state=IDLE, busy=0.
- Counters, per requester i, per cycle: +1 if req[i]; -1 if granted; both in the same cycle leaves it unchanged.
- Saturation: if a counter is at max and req[i] arrives without a grant, the req is dropped and ovf[i] is set.
- Credits, per cycle: -1 on issue; +1 on credit_ret; both in the same cycle leaves it unchanged.
- Credit overflow: credit_ret at credits==CREDITS with no issue leaves credits unchanged and sets cred_err.
- Issue condition: state==RUN and credits>0 and at least one counter non-zero.
- Grant selection: combinational from registered counters; the search starts at rr+1 and wraps modulo NREQ. On issue, rr takes the granted index.
- Output timing: out_pulse and out_id are registered. A req sampled at edge E0 gives out_pulse high after E1, a two-edge latency.
- Back-to-back issues are allowed every cycle while credits last.
- FSM state IDLE:
  - enable=1 goes to RUN.
  - flush=1 goes to FLUSH; flush has priority over enable.
- FSM state RUN:
  - issues per the issue condition.
  - enable=0 goes to IDLE; counters are retained.
  - flush=1 goes to FLUSH.
- FSM state FLUSH:
  - all counters clear on entry; req is ignored and ovf is not set.
  - no issue.
  - stays until credits==CREDITS, then goes to IDLE.
- Simultaneous events:
  - flush in RUN in the same cycle as an issuing decision: that issue still completes.
  - credit_ret continues to be counted in FLUSH.
- Sticky flags clear only on reset.
- Reset mid-operation forces all reset values immediately, including a cancelled out_pulse.

Test Plan:
- Basic issue: enable=1; req=0001 pulsed once → one out_pulse after 2 edges with out_id=0; credits goes 7→6; credit_ret → credits=7.
- Round-robin: preload counters {3,0,2,1} with enable=0, then enable=1 and credit_ret every cycle → out_id sequence 0,2,3,0,2,0; busy falls afterwards.
- Credit stall: req[1] pulsed 10 times, no credit_ret → exactly 7 out_pulse and credits=0. Three credit_ret → 3 more pulses, 0 left pending.
- Saturation: with CNT_W=4 and enable=0, 16 pulses on req[2] → counter=15 and ovf=0100. Then enable=1 with ample credit_ret → exactly 15 pulses with out_id=2.
- Flush: 5 pending on req[3] and 3 credits outstanding; flush → no further out_pulse; busy stays 1 until the 3 credit_ret arrive, then 0 and state IDLE.
- Errors and reset: credit_ret at credits=7 → cred_err=1 and credits stays 7. Assert rstn=0 during a burst → out_pulse=0 immediately; after release credits=7 and cred_err=0.
